// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I opcode constants, control-bundle types and decode helpers
// used by the ctrl_decode_pipe decoder and its elastic output pipeline.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic        illegal;
        alu_op_e     alu_op;
        logic [2:0]  mask;
        logic [2:0]  br_type;
        logic        reg_wr;
        logic        sel_a;
        logic        sel_b;
        logic        rd_en;
        logic        wr_en;
        wb_sel_e     wb_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        illegal: 1'b0,
        alu_op:  ALU_ADD,
        mask:    3'd0,
        br_type: 3'd0,
        reg_wr:  1'b0,
        sel_a:   1'b0,
        sel_b:   1'b0,
        rd_en:   1'b0,
        wr_en:   1'b0,
        wb_sel:  WB_ALU
    };

    // Base (func7 = 0) ALU operation for R/I arithmetic
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3);
        case (funct3)
            3'd0:    alu_from_funct3 = ALU_ADD;
            3'd1:    alu_from_funct3 = ALU_SLL;
            3'd2:    alu_from_funct3 = ALU_SLT;
            3'd3:    alu_from_funct3 = ALU_SLTU;
            3'd4:    alu_from_funct3 = ALU_XOR;
            3'd5:    alu_from_funct3 = ALU_SRL;
            3'd6:    alu_from_funct3 = ALU_OR;
            3'd7:    alu_from_funct3 = ALU_AND;
            default: alu_from_funct3 = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational RV32I instruction -> control bundle decoder with
// illegal-encoding detection; EN_EXT gates JALR/AUIPC support.
module ctrl_decode_comb
    import riscv_ctrl_pkg::*;
#(
    parameter bit EN_EXT = 1'b0
) (
    input  logic [31:0] instruction,
    output ctrl_t       ctrl
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       legal_s;
    ctrl_t      ctrl_s;
    logic       unused_fields_s;

    assign opcode_s        = instruction[6:0];
    assign funct3_s        = instruction[14:12];
    assign funct7_s        = instruction[31:25];
    assign unused_fields_s = ^{instruction[24:15], instruction[11:7]};

    // Opcode decode; legal_s drops on any unsupported encoding
    always_comb begin
        ctrl_s  = CTRL_NOP;
        legal_s = 1'b1;
        case (opcode_s)
            OPC_R: begin
                ctrl_s.reg_wr = 1'b1;
                ctrl_s.sel_a  = 1'b1;
                if (funct7_s == F7_BASE) begin
                    ctrl_s.alu_op = alu_from_funct3(funct3_s);
                end else if ((funct7_s == F7_ALT) && (funct3_s == 3'd0)) begin
                    ctrl_s.alu_op = ALU_SUB;
                end else if ((funct7_s == F7_ALT) && (funct3_s == 3'd5)) begin
                    ctrl_s.alu_op = ALU_SRA;
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_I: begin
                ctrl_s.reg_wr = 1'b1;
                ctrl_s.sel_a  = 1'b1;
                ctrl_s.sel_b  = 1'b1;
                ctrl_s.alu_op = alu_from_funct3(funct3_s);
                case (funct3_s)
                    3'd1: legal_s = (funct7_s == F7_BASE);
                    3'd5: begin
                        if (funct7_s == F7_ALT) begin
                            ctrl_s.alu_op = ALU_SRA;
                        end else if (funct7_s == F7_BASE) begin
                            ctrl_s.alu_op = ALU_SRL;
                        end else begin
                            legal_s = 1'b0;
                        end
                    end
                    default: legal_s = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl_s.reg_wr = 1'b1;
                ctrl_s.sel_a  = 1'b1;
                ctrl_s.sel_b  = 1'b1;
                ctrl_s.rd_en  = 1'b1;
                ctrl_s.wb_sel = WB_MEM;
                ctrl_s.mask   = funct3_s;
                legal_s       = !((funct3_s == 3'd3) || (funct3_s == 3'd6) || (funct3_s == 3'd7));
            end
            OPC_STORE: begin
                ctrl_s.sel_a = 1'b1;
                ctrl_s.sel_b = 1'b1;
                ctrl_s.wr_en = 1'b1;
                ctrl_s.mask  = funct3_s;
                legal_s      = (funct3_s <= 3'd2);
            end
            OPC_BRANCH: begin
                ctrl_s.sel_b   = 1'b1;
                ctrl_s.br_type = funct3_s;
                legal_s        = !((funct3_s == 3'd2) || (funct3_s == 3'd3));
            end
            OPC_LUI: begin
                ctrl_s.alu_op = ALU_PASSB;
                ctrl_s.reg_wr = 1'b1;
                ctrl_s.sel_b  = 1'b1;
            end
            OPC_JAL: begin
                ctrl_s.reg_wr = 1'b1;
                ctrl_s.sel_b  = 1'b1;
                ctrl_s.wb_sel = WB_PC4;
            end
            OPC_JALR: begin
                ctrl_s.reg_wr = 1'b1;
                ctrl_s.sel_a  = 1'b1;
                ctrl_s.sel_b  = 1'b1;
                ctrl_s.wb_sel = WB_PC4;
                legal_s       = EN_EXT;
            end
            OPC_AUIPC: begin
                ctrl_s.reg_wr = 1'b1;
                ctrl_s.sel_b  = 1'b1;
                legal_s       = EN_EXT;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Illegal encodings collapse to an inert bundle flagged illegal
    always_comb begin
        if (legal_s) begin
            ctrl = ctrl_s;
        end else begin
            ctrl         = CTRL_NOP;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// RV32I control decoder followed by PIPE_STAGES elastic valid/ready registers,
// with synchronous flush and a saturating illegal-instruction counter.
module ctrl_decode_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int PIPE_STAGES = 1,
    parameter bit EN_EXT      = 1'b0,
    parameter int ILL_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instruction,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_op,
    output logic [2:0]           mask,
    output logic [2:0]           br_type,
    output logic                 reg_wr,
    output logic                 sel_A,
    output logic                 sel_B,
    output logic                 rd_en,
    output logic                 wr_en,
    output logic [1:0]           wb_sel,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam logic [ILL_CNT_W-1:0] CNT_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

    ctrl_t                  dec_s;
    ctrl_t                  stage_s [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid_s;
    logic [PIPE_STAGES-1:0] ready_s;
    logic                   accept_s;
    logic [ILL_CNT_W-1:0]   ill_cnt_r;
    ctrl_t                  last_s;

    ctrl_decode_comb #(
        .EN_EXT (EN_EXT)
    ) u_decode (
        .instruction (instruction),
        .ctrl        (dec_s)
    );

    // Ready ripples back from the output so bubbles collapse at full throughput
    always_comb begin
        ready_s                = '0;
        ready_s[PIPE_STAGES-1] = !valid_s[PIPE_STAGES-1] || out_ready;
        for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
            ready_s[k] = !valid_s[k] || ready_s[k+1];
        end
    end

    assign in_ready = ready_s[0] && !flush && !reset;
    assign accept_s = in_valid && in_ready;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        logic  prev_valid_s;
        ctrl_t prev_ctrl_s;
        logic  valid_r;
        ctrl_t ctrl_r;

        if (k == 0) begin : g_head
            assign prev_valid_s = accept_s;
            assign prev_ctrl_s  = dec_s;
        end else begin : g_body
            assign prev_valid_s = valid_s[k-1];
            assign prev_ctrl_s  = stage_s[k-1];
        end

        // Elastic slot: refill whenever empty or draining, hold otherwise
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_r <= 1'b0;
                ctrl_r  <= CTRL_NOP;
            end else if (flush) begin
                valid_r <= 1'b0;
            end else if (ready_s[k]) begin
                valid_r <= prev_valid_s;
                if (prev_valid_s) begin
                    ctrl_r <= prev_ctrl_s;
                end
            end
        end

        assign valid_s[k] = valid_r;
        assign stage_s[k] = ctrl_r;
    end

    // Counts illegal instructions at acceptance, so later flushes do not undo it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ill_cnt_r <= '0;
        end else if (accept_s && dec_s.illegal && (ill_cnt_r != '1)) begin
            ill_cnt_r <= ill_cnt_r + CNT_ONE;
        end
    end

    assign last_s    = stage_s[PIPE_STAGES-1];
    assign out_valid = valid_s[PIPE_STAGES-1];
    assign alu_op    = last_s.alu_op;
    assign mask      = last_s.mask;
    assign br_type   = last_s.br_type;
    assign reg_wr    = last_s.reg_wr;
    assign sel_A     = last_s.sel_a;
    assign sel_B     = last_s.sel_b;
    assign rd_en     = last_s.rd_en;
    assign wr_en     = last_s.wr_en;
    assign wb_sel    = last_s.wb_sel;
    assign illegal   = last_s.illegal;
    assign ill_cnt   = ill_cnt_r;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Scoreboard bench for ctrl_decode_pipe (PIPE_STAGES=2, EN_EXT=0, ILL_CNT_W=2).
module tb_ctrl_decode_pipe;

    localparam int PS = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   instruction = 32'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    alu_op;
    logic [2:0]    mask;
    logic [2:0]    br_type;
    logic          reg_wr, sel_A, sel_B, rd_en, wr_en, illegal;
    logic [1:0]    wb_sel;
    logic [CW-1:0] ill_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ill_model = 0;
    int          t0;
    logic [17:0] exp_q [$];
    logic [17:0] cur_exp = 18'd0;
    logic [17:0] bundle_s;
    logic        rnd_on = 1'b0;
    logic [31:0] vi [$];
    logic [17:0] ve [$];

    ctrl_decode_pipe #(
        .PIPE_STAGES (PS),
        .EN_EXT      (1'b0),
        .ILL_CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .mask        (mask),
        .br_type     (br_type),
        .reg_wr      (reg_wr),
        .sel_A       (sel_A),
        .sel_B       (sel_B),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .wb_sel      (wb_sel),
        .illegal     (illegal),
        .ill_cnt     (ill_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bundle_s = {illegal, alu_op, mask, br_type, reg_wr, sel_A, sel_B, rd_en, wr_en, wb_sel};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [17:0] pk(input logic il, input logic [3:0] op, input logic [2:0] m,
                                       input logic [2:0] br, input logic rw, input logic sa,
                                       input logic sb, input logic rd, input logic wr,
                                       input logic [1:0] wb);
        return {il, op, m, br, rw, sa, sb, rd, wr, wb};
    endfunction

    // Scoreboard: check output front, pop on transfer, drop on flush, push on accept
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", 32'(in_ready), 32'(!flush && ((exp_q.size() < PS) || out_ready)));
            check("ill_cnt", 32'(ill_cnt), ill_model);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    check("bundle", 32'(bundle_s), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (flush) exp_q.delete();
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                if (cur_exp[17] && (ill_model < (2**CW - 1))) ill_model++;
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [17:0] e);
        logic acc;
        acc         = 1'b0;
        instruction = ins;
        cur_exp     = e;
        in_valid    = 1'b1;
        for (int t = 0; (t < 50) && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; (t < 30) && (exp_q.size() != 0); t++) @(negedge clk);
        check("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic lat_check(input logic [31:0] ins, input logic [17:0] e);
        send(ins, e);
        in_valid = 1'b0;
        for (int i = 1; i < PS; i++) begin
            @(negedge clk);
            check("lat_early", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("lat_due", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] e_add, e_ill;
        e_add = pk(1'b0, 4'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        e_ill = pk(1'b1, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        #1 reset = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ill_cnt", 32'(ill_cnt), 32'd0);
        check("rst_bundle", 32'(bundle_s), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        lat_check(32'h003100B3, e_add);

        t0 = cyc;
        send(32'h403100B3, pk(1'b0, 4'd1, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        send(32'h4050D093, pk(1'b0, 4'd7, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
        send(32'h0080A283, pk(1'b0, 4'd0, 3'd2, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
        in_valid = 1'b0;
        check("throughput", cyc - t0, 32'd3);
        drain();

        // stall with continuous input; release after 4 cycles
        out_ready = 1'b0;
        fork
            begin
                send(32'h003100B3, e_add);
                send(32'h0020F1B3, pk(1'b0, 4'd9, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
                send(32'h0020D1B3, pk(1'b0, 4'd6, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
                send(32'h00309093, pk(1'b0, 4'd2, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("stall_full_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(32'h0000007F, e_ill);
        send(32'h000080E7, e_ill);
        in_valid = 1'b0;
        drain();
        check("ill_cnt_two", 32'(ill_cnt), 32'd2);
        send(32'h023100B3, e_ill);
        send(32'h0020B223, e_ill);
        send(32'h0020A463, e_ill);
        in_valid = 1'b0;
        drain();
        check("ill_cnt_sat", 32'(ill_cnt), 32'd3);

        vi.push_back(32'h0020A223); ve.push_back(pk(1'b0, 4'd0, 3'd2, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0));
        vi.push_back(32'h00208463); ve.push_back(pk(1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
        vi.push_back(32'h00209463); ve.push_back(pk(1'b0, 4'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
        vi.push_back(32'h123450B7); ve.push_back(pk(1'b0, 4'd10, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
        vi.push_back(32'h008000EF); ve.push_back(pk(1'b0, 4'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2));
        vi.push_back(32'h0030B093); ve.push_back(pk(1'b0, 4'd4, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
        vi.push_back(32'h0020C1B3); ve.push_back(pk(1'b0, 4'd5, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        vi.push_back(32'h0020A1B3); ve.push_back(pk(1'b0, 4'd3, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        vi.push_back(32'h0020E1B3); ve.push_back(pk(1'b0, 4'd8, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        vi.push_back(32'h403110B3); ve.push_back(e_ill);
        vi.push_back(32'h00001097); ve.push_back(e_ill);
        vi.push_back(32'h0000B283); ve.push_back(e_ill);
        vi.push_back(32'h40309093); ve.push_back(e_ill);

        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < vi.size(); i++) send(vi[i], ve[i]);
                in_valid = 1'b0;
                rnd_on   = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // flush with two entries in flight; offered input must be refused
        out_ready = 1'b0;
        send(32'h003100B3, e_add);
        send(32'h403100B3, pk(1'b0, 4'd1, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        instruction = 32'h0080A283;
        cur_exp     = pk(1'b0, 4'd0, 3'd2, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        flush       = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        lat_check(32'h0080A283, cur_exp);
        drain();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h003100B3, e_add);
        send(32'h0000007F, e_ill);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_ill_cnt", 32'(ill_cnt), 32'd0);
        exp_q.delete();
        ill_model = 0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        lat_check(32'h003100B3, e_add);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
